// File: rtl/fp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mac_pipe
// Description : Pipelined fixed-point multiply-accumulate for the FPU
//               divide/sqrt datapath: d = (a << (WIDTH-2)) +/- b*c or
//               d = acc +/- b*c, with valid/ready handshake and backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mac_pipe #(
    parameter int WIDTH   = 27,
    parameter int LATENCY = 2,
    localparam int RW     = 2 * WIDTH - 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [RW-1:0]    d
);

    localparam int c_NS = (LATENCY > 1) ? LATENCY - 1 : 1;

    generate
        if (LATENCY < 1 || LATENCY > 4 || WIDTH < 4) begin : g_param_err
            $error("fp_mac_pipe: LATENCY must be 1..4 and WIDTH must be >= 4");
        end
    endgenerate

    logic            w_adv;
    logic [RW-1:0]   w_b_ext;
    logic [RW-1:0]   w_c_ext;
    logic [RW-1:0]   w_prod;

    logic            w_last_vld;
    logic [1:0]      w_last_op;
    logic [WIDTH-1:0] w_last_a;
    logic [RW-1:0]   w_last_p;

    logic [RW-1:0]   w_base;
    logic [RW-1:0]   w_m;
    logic [RW-1:0]   w_sum;
    logic [RW-1:0]   r_acc;

    // Whole pipeline moves in lock-step whenever the output slot is free.
    assign w_adv   = !valid_o || ready_i;
    assign ready_o = w_adv;

    // Only the low RW product bits are kept, so an RW x RW modular multiply
    // of the sign-extended operands gives exactly those bits.
    assign w_b_ext = {{(WIDTH-2){b[WIDTH-1]}}, b};
    assign w_c_ext = {{(WIDTH-2){c[WIDTH-1]}}, c};
    assign w_prod  = w_b_ext * w_c_ext;

    generate
        if (LATENCY == 1) begin : g_comb
            assign w_last_vld = valid_i;
            assign w_last_op  = op;
            assign w_last_a   = a;
            assign w_last_p   = w_prod;
        end else begin : g_pipe
            logic [c_NS-1:0]  r_vld;
            logic [1:0]       r_op [c_NS];
            logic [WIDTH-1:0] r_a  [c_NS];
            logic [RW-1:0]    r_p  [c_NS];

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_vld <= '0;
                    for (int i = 0; i < c_NS; i++) begin
                        r_op[i] <= '0;
                        r_a[i]  <= '0;
                        r_p[i]  <= '0;
                    end
                end else if (w_adv) begin
                    r_vld[0] <= valid_i;
                    r_op[0]  <= op;
                    r_a[0]   <= a;
                    r_p[0]   <= w_prod;
                    for (int i = 1; i < c_NS; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_op[i]  <= r_op[i-1];
                        r_a[i]   <= r_a[i-1];
                        r_p[i]   <= r_p[i-1];
                    end
                end
            end

            assign w_last_vld = r_vld[c_NS-1];
            assign w_last_op  = r_op[c_NS-1];
            assign w_last_a   = r_a[c_NS-1];
            assign w_last_p   = r_p[c_NS-1];
        end
    endgenerate

    // op[1] selects the accumulator as base, op[0] negates the product.
    assign w_base = w_last_op[1] ? r_acc : {w_last_a, {(WIDTH-2){1'b0}}};
    assign w_m    = w_last_op[0] ? (-w_last_p) : w_last_p;
    assign w_sum  = w_base + w_m;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_o <= 1'b0;
            d       <= '0;
            r_acc   <= '0;
        end else if (w_adv) begin
            valid_o <= w_last_vld;
            if (w_last_vld) begin
                d     <= w_sum;
                r_acc <= w_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fp_mac_pipe.md
Name: fp_mac_pipe

Overview:
- Parametrised, pipelined fixed-point multiply-accumulate unit for the iterative divide/sqrt datapath of the FPU.
- Computes d = (a << (WIDTH-2)) ± b*c, or d = acc ± b*c using an internal accumulator.
- Configurable operand width and pipeline depth; valid/ready handshake with full backpressure.

Parameters:
- WIDTH, 27, signed operand width of a, b, c; result width is RW = 2*WIDTH-2.
- LATENCY, 2, pipeline depth in cycles, legal range 1..4.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- valid_i  input  1  input beat valid
- ready_o  output  1  unit can accept a beat this cycle
- op  input  2  0: add-a; 1: sub-a; 2: add-acc; 3: sub-acc
- a  input  WIDTH  signed addend; ignored for op 2/3
- b  input  WIDTH  signed multiplicand
- c  input  WIDTH  signed multiplier
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- d  output  RW  result, two's complement

Behaviour:
- Reset (reset=0, asynchronous) clears the following to 0: all stage valid bits, valid_o, d, the accumulator and all pipeline data registers. ready_o is 1 after reset.
- Advance rule: adv = !valid_o || ready_i.
  - ready_o = adv, combinational.
  - Accept = valid_i && ready_o.
  - When adv=0, every stage register, d, valid_o and acc hold unchanged.
- The pipeline does not compress bubbles; all stages shift together on adv.
- Product: p = signed(b)*signed(c), full 2*WIDTH bits, truncated to its low RW bits.
  - p is computed from the input operands and carried through LATENCY-1 product registers with op and a.
  - For LATENCY=1, p is not registered; d is written on the accept edge.
- Output stage, on the edge where the last internal stage (or the input, for LATENCY=1) holds a valid beat and adv=1:
  - base = {a, (WIDTH-2)'b0} for op 0/1; base = acc for op 2/3.
  - m = p for op 0/2; m = -p (mod 2^RW) for op 1/3.
  - d <= base + m, mod 2^RW. Wrap-around is silent; there is no overflow flag.
  - acc <= the same value; every op updates acc.
  - valid_o <= 1.
- If adv=1 and no valid beat reaches the output stage: valid_o <= 0, while d and acc hold.
- Latency: a beat accepted on edge k is presented with valid_o=1 after edge k+LATENCY-1, provided there is no stall. Throughput is 1 beat/cycle.
- Accumulation dependency: op 2/3 uses acc as left by the immediately preceding beat to pass the output stage. Back-to-back accumulate chains are therefore correct at any LATENCY with no hazard stall.
- Simultaneous valid_o && ready_i && arriving beat: the new result replaces d in the same edge; no loss and no duplication.
- Stall with valid_i=1 and ready_o=0: the input beat is not accepted, and the source must hold it.
- Reset mid-operation: all in-flight beats are discarded, acc=0, and no valid_o pulse occurs after reset release until new beats are accepted.
- Parameter check: LATENCY outside 1..4 or WIDTH<4 is an elaboration-time error.

Test Plan:
1. WIDTH=27, LATENCY=2. Inputs: op=0, a=1, b=2, c=3. Expect d=0x2000006 with valid_o=1 on the 2nd edge after accept. Then op=1 with the same operands: expect d=0x1FFFFFA.
2. Negative product: op=0, a=0, b=0x7FFFFFF (-1), c=1. Expect d=0xFFFFFFFFFFFFF (-1 in 52 bits).
3. Wrap-around: op=0, a=0x3FFFFFF, b=c=0x4000000. The product 2^52 truncates to 0, so expect d=0x7FFFFFE000000.
4. Back-to-back accumulate, ready_i=1, one beat per cycle:
   - (op0, a=0, b=3, c=4) gives 12.
   - (op2, b=5, c=5) gives 37.
   - (op3, b=1, c=7) gives 30.
   - Expect results on three consecutive cycles. Repeat with LATENCY=1 and LATENCY=4 for identical values.
5. Backpressure: stream 5 beats and drop ready_i for 3 cycles mid-stream. Expect:
   - d and valid_o held stable throughout the stall.
   - ready_o=0 while valid_o=1 and ready_i=0.
   - All 5 results delivered in order, with none lost or duplicated.
6. Reset mid-stream with 2 beats in flight and acc=37. Expect valid_o=0 and d=0 immediately, with no spurious output afterwards. A following op2 with b=1, c=1 yields d=1, confirming acc was cleared.
